// File: rtl/axil_pkg.sv
// axil_pkg: AXI-Lite response codes and helpers shared by the
// read path (axil_rom_pipe) and the future write-response path.
package axil_pkg;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_EXOKAY = 2'b01,
    AXIL_SLVERR = 2'b10,
    AXIL_DECERR = 2'b11
  } axil_resp_e;

  function automatic logic resp_is_err(input axil_resp_e r);
    return (r != AXIL_OKAY);
  endfunction

endpackage

// File: rtl/axil_rom_pipe_if.sv
// axil_rom_pipe_if: AXI-Lite read channels (AR + R) bundled with
// master/slave views.
interface axil_rom_pipe_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    output axi_araddr, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );

  modport slave (
    input  axi_araddr, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );

endinterface

// File: rtl/axil_resp_fifo.sv
// axil_resp_fifo: synchronous first-word-fall-through FIFO with
// occupancy count; shared by AXI-Lite response paths.
module axil_resp_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

endmodule

// File: rtl/axil_rom_pipe.sv
// axil_rom_pipe: AXI-Lite read-only slave in front of a 1-cycle ROM/RAM.
// Define AXIL_ROM_ERR_CNT_EN to add the saturating err_count output.
module axil_rom_pipe
  import axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_START   = 'h00000000,
  parameter logic [ADDR_WIDTH-1:0] MEM_STOP    = 'h00000400,
  parameter int unsigned           RESP_DEPTH  = 4,
  parameter int unsigned           ALIGN_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axil_rom_pipe_if.slave        axi,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef AXIL_ROM_ERR_CNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  typedef struct packed {
    axil_resp_e            resp;
    logic [DATA_WIDTH-1:0] data;
  } axil_rsp_t;

  localparam int unsigned RSP_W = $bits(axil_rsp_t);
  localparam int unsigned CW    = $clog2(RESP_DEPTH+1);
  localparam int unsigned LSB   = $clog2(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

  logic [ADDR_WIDTH:0] w_diff;
  logic                w_dec;
  logic                w_slv;
  logic                w_accept;
  axil_resp_e          w_cls;
  logic [CW-1:0]       w_count;
  logic [CW:0]         w_occ;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  axil_rsp_t           w_din;
  axil_rsp_t           w_head;

  logic                r_inflight;
  axil_resp_e          r_resp;

  // Borrow out of the subtraction flags addresses below MEM_START.
  assign w_diff    = {1'b0, axi.axi_araddr} - {1'b0, MEM_START};
  assign mem_raddr = w_diff[ADDR_WIDTH-1:0];

  assign w_dec = w_diff[ADDR_WIDTH] | (axi.axi_araddr >= MEM_STOP);
  assign w_slv = ~w_dec & (ALIGN_CHECK != 0) &
                 (|(axi.axi_araddr & ALIGN_MASK));

  always_comb begin
    w_cls = AXIL_OKAY;
    unique case (1'b1)
      w_dec:   w_cls = AXIL_DECERR;
      w_slv:   w_cls = AXIL_SLVERR;
      default: w_cls = AXIL_OKAY;
    endcase
  end

  // Credit: a slot is reserved for the read still in the memory stage.
  assign w_occ = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign axi.axi_arready = rst_n & (w_occ < (CW+1)'(RESP_DEPTH));

  assign w_accept = axi.axi_arvalid & axi.axi_arready;
  assign mem_ren  = w_accept & ~resp_is_err(w_cls);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_resp     <= AXIL_OKAY;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) r_resp <= w_cls;
    end
  end

  assign w_push      = r_inflight & ~w_full;
  assign w_din.resp  = r_resp;
  assign w_din.data  = (r_resp == AXIL_OKAY) ? mem_rdata : '0;
  assign w_pop       = axi.axi_rvalid & axi.axi_rready;

  axil_resp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign axi.axi_rvalid = ~w_empty;
  assign axi.axi_rdata  = w_empty ? '0 : w_head.data;
  assign axi.axi_rresp  = w_empty ? AXIL_OKAY : w_head.resp;

`ifdef AXIL_ROM_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_push && resp_is_err(r_resp) &&
                 (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule
